// File: rtl/varredor_mux16.sv
// varredor_mux16 -- sweeps the 4-bit select of an external 16x1 multiplexer
// over channels 0..15, waits SETTLE cycles on each channel for the mux output
// to settle, captures it and hands it to a consumer with a valido/pronto
// handshake.
//
// Parameters
//   BITS    width of each channel value (dado_mux / dado)
//   SETTLE  cycles sel is held stable before sampling, 1..15
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   iniciar   in   start request, only looked at while idle
//   dado_mux  in   multiplexer output for the current sel
//   pronto    in   consumer ready
//   sel       out  channel select driven to the multiplexer
//   canal     out  channel index of the value on dado
//   dado      out  captured channel value
//   valido    out  dado/canal valid
//   ocupado   out  high whenever the sweeper is not idle
//   fim       out  one-cycle pulse after the channel-15 handshake
//
// Build option
//   VARREDOR_CONTINUO_EN  when defined, a channel-15 handshake with iniciar=1
//                         starts the next sweep immediately instead of idling.

module varredor_mux16 #(
    parameter int BITS   = 4,
    parameter int SETTLE = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            iniciar,
    input  logic [BITS-1:0] dado_mux,
    input  logic            pronto,
    output logic [3:0]      sel,
    output logic [3:0]      canal,
    output logic [BITS-1:0] dado,
    output logic            valido,
    output logic            ocupado,
    output logic            fim
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    localparam logic [3:0] LP_CNT_MAX = 4'(SETTLE - 1);

    estado_t         r_estado, w_estado_nxt;
    logic [3:0]      r_sel,    w_sel_nxt;
    logic [3:0]      r_cnt,    w_cnt_nxt;
    logic [3:0]      r_canal,  w_canal_nxt;
    logic [BITS-1:0] r_dado,   w_dado_nxt;
    logic            r_valido, w_valido_nxt;
    logic            r_fim,    w_fim_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_canal  <= '0;
            r_dado   <= '0;
            r_valido <= 1'b0;
            r_fim    <= 1'b0;
        end else begin
            r_estado <= w_estado_nxt;
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
            r_canal  <= w_canal_nxt;
            r_dado   <= w_dado_nxt;
            r_valido <= w_valido_nxt;
            r_fim    <= w_fim_nxt;
        end
    end

    always_comb begin
        w_estado_nxt = r_estado;
        w_sel_nxt    = r_sel;
        w_cnt_nxt    = r_cnt;
        w_canal_nxt  = r_canal;
        w_dado_nxt   = r_dado;
        w_valido_nxt = r_valido;
        w_fim_nxt    = 1'b0;

        case (r_estado)
            OCIOSO: begin
                if (iniciar) begin
                    w_estado_nxt = ESPERA;
                    w_sel_nxt    = '0;
                    w_cnt_nxt    = '0;
                end
            end

            ESPERA: begin
                if (r_cnt == LP_CNT_MAX) begin
                    w_dado_nxt   = dado_mux;
                    w_canal_nxt  = r_sel;
                    w_valido_nxt = 1'b1;
                    w_estado_nxt = ENTREGA;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end

            ENTREGA: begin
                // Only pronto seen while valido is already high completes a
                // handshake; pronto during the capture edge is ignored.
                if (r_valido && pronto) begin
                    w_valido_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    if (r_sel != 4'hF) begin
                        w_sel_nxt    = r_sel + 4'd1;
                        w_estado_nxt = ESPERA;
                    end else begin
                        w_fim_nxt = 1'b1;
                        w_sel_nxt = '0;
`ifdef VARREDOR_CONTINUO_EN
                        w_estado_nxt = iniciar ? ESPERA : OCIOSO;
`else
                        w_estado_nxt = OCIOSO;
`endif
                    end
                end
            end

            default: begin
                w_estado_nxt = OCIOSO;
            end
        endcase
    end

    assign sel     = r_sel;
    assign canal   = r_canal;
    assign dado    = r_dado;
    assign valido  = r_valido;
    assign ocupado = (r_estado != OCIOSO);
    assign fim     = r_fim;

endmodule

// File: tb/tb_varredor_mux16.sv
module tb_varredor_mux16;

    logic       clock;
    logic       reset;
    logic       iniciar, pronto;
    logic [3:0] dado_mux;
    logic [3:0] sel, canal, dado;
    logic       valido, ocupado, fim;

    logic       iniciar1, pronto1;
    logic [3:0] dado_mux1;
    logic [3:0] sel1, canal1, dado1;
    logic       valido1, ocupado1, fim1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    varredor_mux16 #(.BITS(4), .SETTLE(2)) u_dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .dado_mux(dado_mux),
        .pronto(pronto), .sel(sel), .canal(canal), .dado(dado),
        .valido(valido), .ocupado(ocupado), .fim(fim)
    );

    varredor_mux16 #(.BITS(4), .SETTLE(1)) u_dut1 (
        .clock(clock), .reset(reset), .iniciar(iniciar1), .dado_mux(dado_mux1),
        .pronto(pronto1), .sel(sel1), .canal(canal1), .dado(dado1),
        .valido(valido1), .ocupado(ocupado1), .fim(fim1)
    );

    // Multiplexer models: channel value is sel ^ A, second instance sees constant F.
    assign dado_mux  = sel ^ 4'hA;
    assign dado_mux1 = 4'hF;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_expected(input logic [3:0] fixed, input bit use_fixed);
        exp_q.delete();
        for (int c = 0; c < 16; c++) begin
            logic [3:0] cc;
            cc = 4'(c);
            exp_q.push_back({cc, use_fixed ? fixed : (cc ^ 4'hA)});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; iniciar = 1'b0; pronto = 1'b0; iniciar1 = 1'b0; pronto1 = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b1; pronto = 1'b1; iniciar1 = 1'b1; pronto1 = 1'b1;
        tick();
        tick();
        checks++;
        if ({sel, canal, dado, valido, ocupado, fim} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got %0h want 0", {sel, canal, dado, valido, ocupado, fim});
        end
        checks++;
        if ({sel1, canal1, dado1, valido1, ocupado1, fim1} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs_s1 got %0h want 0", {sel1, canal1, dado1, valido1, ocupado1, fim1});
        end
        reset = 1'b0; iniciar = 1'b0; pronto = 1'b0; iniciar1 = 1'b0; pronto1 = 1'b0;
        tick();
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got %0b want 0", ocupado);
        end
    endtask

    task automatic test_sweep();
        int n, nd, first_v;
        bit done;
        logic [7:0] e;
        load_expected(4'h0, 1'b0);
        pronto = 1'b1; iniciar = 1'b1;
        tick(); n = 0;
        iniciar = 1'b0;
        checks++;
        if (ocupado !== 1'b1 || valido !== 1'b0) begin
            errors++;
            $display("FAIL sweep_start got ocupado=%0b valido=%0b want 1 0", ocupado, valido);
        end
        nd = 0; first_v = -1; done = 1'b0;
        while (!done && n < 200) begin
            if (valido) begin
                if (first_v < 0) first_v = n;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sweep_extra got canal=%0h want none", canal);
                end else begin
                    e = exp_q.pop_front();
                    if ({canal, dado} !== e || sel !== canal) begin
                        errors++;
                        $display("FAIL sweep_data got %0h sel=%0h want %0h", {canal, dado}, sel, e);
                    end
                end
                nd++;
            end
            tick(); n++;
            if (fim) done = 1'b1;
        end
        checks++;
        if (!done || n != 48) begin
            errors++;
            $display("FAIL sweep_fim_edge got %0d want 48", n);
        end
        checks++;
        if (first_v != 2) begin
            errors++;
            $display("FAIL sweep_first_valid got %0d want 2", first_v);
        end
        checks++;
        if (nd != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL sweep_count got %0d want 16", nd);
        end
`ifndef VARREDOR_CONTINUO_EN
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL sweep_idle_with_fim got %0b want 0", ocupado);
        end
`endif
        tick();
        checks++;
        if (fim !== 1'b0 || sel !== 4'h0) begin
            errors++;
            $display("FAIL sweep_fim_pulse got fim=%0b sel=%0h want 0 0", fim, sel);
        end
    endtask

    task automatic test_backpressure();
        int n, h, hold, v4;
        logic [7:0] e;
        load_expected(4'h0, 1'b0);
        do_reset();
        iniciar = 1'b1; pronto = 1'b1;
        tick(); n = 0;
        iniciar = 1'b0;
        h = -1; hold = 0; v4 = -1;
        while (!fim && n < 200) begin
            pronto = !(valido && canal == 4'h3 && hold < 7);
            if (valido && canal == 4'h3) begin
                checks++;
                if (dado !== 4'h9 || sel !== 4'h3) begin
                    errors++;
                    $display("FAIL hold_values got dado=%0h sel=%0h want 9 3", dado, sel);
                end
                if (!pronto) hold++;
            end
            if (valido && canal == 4'h4 && v4 < 0) v4 = n;
            if (valido && pronto) begin
                checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                if ({canal, dado} !== e) begin
                    errors++;
                    $display("FAIL hold_data got %0h want %0h", {canal, dado}, e);
                end
                if (canal == 4'h3) h = n + 1;
            end
            tick(); n++;
        end
        checks++;
        if (hold != 7 || h < 0 || v4 - h != 2) begin
            errors++;
            $display("FAIL hold_resume got hold=%0d gap=%0d want 7 2", hold, v4 - h);
        end
        checks++;
        if (!fim || n != 55 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_fim got edge=%0d left=%0d want 55 0", n, exp_q.size());
        end
        pronto = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        iniciar = 1'b1; pronto = 1'b1;
        tick(); n = 0;
        iniciar = 1'b0;
        while (!(valido && canal == 4'h8) && n < 200) begin
            tick(); n++;
        end
        pronto = 1'b0;
        tick();
        reset = 1'b1; iniciar = 1'b1; pronto = 1'b1;
        tick();
        checks++;
        if ({sel, canal, dado, valido, ocupado, fim} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid got %0h want 0", {sel, canal, dado, valido, ocupado, fim});
        end
        reset = 1'b0; iniciar = 1'b0;
        tick();
        checks++;
        if (ocupado !== 1'b0 || valido !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle got ocupado=%0b valido=%0b want 0 0", ocupado, valido);
        end
        iniciar = 1'b1;
        tick(); n = 0;
        iniciar = 1'b0;
        while (!valido && n < 50) begin
            tick(); n++;
        end
        checks++;
        if (n != 2 || canal !== 4'h0 || dado !== 4'hA) begin
            errors++;
            $display("FAIL reset_mid_restart got edge=%0d canal=%0h dado=%0h want 2 0 A", n, canal, dado);
        end
    endtask

    task automatic test_iniciar_held();
        int n, nv;
        logic [7:0] e;
        bit gap;
        load_expected(4'h0, 1'b0);
        do_reset();
        iniciar = 1'b1; pronto = 1'b1;
        tick(); n = 0;
        while (!fim && n < 200) begin
            if (valido) begin
                checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                if ({canal, dado} !== e) begin
                    errors++;
                    $display("FAIL held_data got %0h want %0h", {canal, dado}, e);
                end
            end
            tick(); n++;
        end
        checks++;
        if (n != 48 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL held_fim got edge=%0d left=%0d want 48 0", n, exp_q.size());
        end
        gap = 1'b0;
        nv = n;
        while (!valido && nv < n + 20) begin
            if (!ocupado) gap = 1'b1;
            tick(); nv++;
        end
`ifdef VARREDOR_CONTINUO_EN
        checks++;
        if (nv != 50 || gap || canal !== 4'h0) begin
            errors++;
            $display("FAIL held_next got edge=%0d gap=%0b canal=%0h want 50 0 0", nv, gap, canal);
        end
`else
        checks++;
        if (nv != 51 || !gap || canal !== 4'h0) begin
            errors++;
            $display("FAIL held_next got edge=%0d gap=%0b canal=%0h want 51 1 0", nv, gap, canal);
        end
`endif
        iniciar = 1'b0;
    endtask

    task automatic test_settle1();
        int n, nd, prev;
        logic [7:0] e;
        load_expected(4'hF, 1'b1);
        do_reset();
        iniciar1 = 1'b1; pronto1 = 1'b1;
        tick(); n = 0;
        iniciar1 = 1'b0;
        nd = 0; prev = -1;
        while (!fim1 && n < 200) begin
            if (valido1) begin
                checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                if ({canal1, dado1} !== e || n != prev + 2) begin
                    errors++;
                    $display("FAIL settle1_data got %0h at %0d want %0h at %0d", {canal1, dado1}, n, e, prev + 2);
                end
                prev = n; nd++;
            end
            tick(); n++;
        end
        checks++;
        if (n != 32 || nd != 16) begin
            errors++;
            $display("FAIL settle1_fim got edge=%0d n=%0d want 32 16", n, nd);
        end
        pronto1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; pronto = 1'b0; iniciar1 = 1'b0; pronto1 = 1'b0;
        test_reset();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_iniciar_held();
        test_settle1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/varredor_mux16.md
VARREDOR_MUX16 -- requirements
Module: varredor_mux16

Interface
REQ-001 The block SHALL have parameter BITS, default 4: width of each channel value read through the 16x1 multiplexer.
REQ-002 The block SHALL have parameter SETTLE, default 2, legal range 1..15: cycles SEL is held stable before sampling.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 iniciar  input  1  start request; sampled only in state OCIOSO.
REQ-007 dado_mux  input  BITS  value returned by the multiplexer for the current sel.
REQ-008 pronto  input  1  consumer ready.
REQ-009 sel  output  4  channel select driven to the multiplexer SEL input.
REQ-010 canal  output  4  channel index of the value on dado.
REQ-011 dado  output  BITS  captured channel value.
REQ-012 valido  output  1  dado/canal valid.
REQ-013 ocupado  output  1  high in every state except OCIOSO.
REQ-014 fim  output  1  one-cycle pulse after the channel-15 handshake.

Function
REQ-015 The FSM SHALL have exactly three states: OCIOSO, ESPERA and ENTREGA.
REQ-016 OCIOSO with iniciar=1 at an edge: next state ESPERA, sel=0, settle counter=0.
REQ-017 ESPERA, counter below SETTLE-1 at an edge: counter increments and sel holds.
REQ-018 ESPERA, counter at SETTLE-1 at an edge: dado<=dado_mux, canal<=sel, valido<=1, next state ENTREGA.
REQ-019 First valido SHALL be high exactly SETTLE cycles after the edge that sampled iniciar.
REQ-020 ENTREGA SHALL hold dado, canal, valido and sel constant while pronto=0, for any number of cycles.
REQ-021 Handshake SHALL occur at an edge where valido=1 and pronto=1; valido then returns to 0.
REQ-022 At a handshake with sel<15: sel<=sel+1, counter<=0, next state ESPERA.
REQ-023 At a handshake with sel=15: fim<=1 for one cycle, sel<=0, and the next state follows REQ-030/REQ-031.
REQ-024 Channel period with pronto held high SHALL be SETTLE+1 cycles; a full sweep spans 16 deliveries, channels 0..15 in order, each exactly once.
REQ-025 iniciar SHALL be ignored outside OCIOSO.
REQ-026 The pronto value seen in the capture cycle SHALL NOT complete a handshake; only pronto sampled while valido=1 counts.
REQ-027 sel SHALL wrap only from 15 to 0 and SHALL never exceed 15.

Reset
REQ-028 reset=1 at an edge SHALL force state OCIOSO, sel=0, canal=0, dado=0, valido=0, ocupado=0, fim=0 and counter=0, from any state including mid-handshake.
REQ-029 reset SHALL take priority over iniciar and pronto at the same edge; no partial delivery resumes afterwards.

Configuration
REQ-030 With VARREDOR_CONTINUO_EN undefined, the channel-15 handshake SHALL always return the FSM to OCIOSO, with ocupado=0 in the same cycle as fim=1.
REQ-031 With VARREDOR_CONTINUO_EN defined, the channel-15 handshake SHALL go to ESPERA with sel=0 if iniciar=1 at that edge, otherwise to OCIOSO; fim pulses in both cases and ocupado stays 1 when continuing.

Verification
REQ-032 BITS=4, SETTLE=2, dado_mux=sel^4'hA, pronto=1, iniciar pulsed at edge 0 -> valido first high after edge 2; canal/dado 0/A,1/B,...,15/5; fim pulses after edge 48; ocupado then 0.
REQ-033 pronto=0 for 7 cycles while channel 3 is valid -> dado=9, canal=3 and sel=3 held all 7 cycles; channel 4 valid SETTLE cycles after pronto rises and is sampled.
REQ-034 reset=1 during ENTREGA of channel 8 -> all outputs 0 next cycle; iniciar ignored that cycle; a new iniciar restarts from channel 0.
REQ-035 iniciar=1 held throughout the sweep without the macro -> exactly 16 deliveries, then OCIOSO, then a new sweep starting one cycle later.
REQ-036 iniciar=1 held with VARREDOR_CONTINUO_EN -> canal sequence 15,0,1 with no OCIOSO cycle; fim pulses once per sweep; dropping iniciar before the channel-15 handshake stops after 15.
REQ-037 SETTLE=1, pronto=1, dado_mux constant 4'hF -> valido high every 2nd cycle; 16 deliveries of F; fim after edge 32.
